// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial link shift registers (PISO transmitter, SIPO receiver).
package shift_reg_pkg;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Bit counter must reach WIDTH when a trailing parity bit is in use.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// Output holding register for the SIPO receiver: valid/ready handshake and sticky overrun.
// Carries a parity error flag alongside the word when SIPO_PARITY_EN is defined.
module sipo_hold_reg
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_valid_i,
  input  logic [WIDTH-1:0] wr_data_i,
`ifdef SIPO_PARITY_EN
  input  logic             wr_perr_i,
  output logic             parity_err_o,
`endif
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             accept;
`ifdef SIPO_PARITY_EN
  logic             perr_q, perr_d;
`endif

  // A completing word is taken if the slot is empty or is being drained on this same edge.
  always_comb begin
    accept    = wr_valid_i && (!valid_q || out_ready_i);
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
`ifdef SIPO_PARITY_EN
    perr_d    = perr_q;
`endif
    if (accept) begin
      data_d  = wr_data_i;
      valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
      perr_d  = wr_perr_i;
`endif
    end else if (wr_valid_i) begin
      overrun_d = 1'b1;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef SIPO_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
`ifdef SIPO_PARITY_EN
  assign parity_err_o = perr_q;
`endif

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: bit counter and shift register feeding a holding register.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit per word and expose parity_err.
module sipo_deserializer
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             shift_en,
  input  logic             shift_dir,
  input  logic             frame_start,
  input  logic             out_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun,
`ifdef SIPO_PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy
);

  localparam int unsigned CntW = cnt_width(WIDTH);
`ifdef SIPO_PARITY_EN
  localparam int unsigned LastCnt = WIDTH;
`else
  localparam int unsigned LastCnt = WIDTH - 1;
`endif
  localparam logic [CntW-1:0] LastCntV = CntW'(LastCnt);
  localparam logic [CntW-1:0] WidthV   = CntW'(WIDTH);

  logic [CntW-1:0]  cnt_q, cnt_d, cnt_eff;
  logic [WIDTH-1:0] sreg_q, sreg_d, sreg_base;
  logic             dir_q, dir_d, dir_eff;
  logic             busy_q;
  logic             word_done;
  logic [WIDTH-1:0] word_data;
`ifdef SIPO_PARITY_EN
  logic             word_perr;
`endif

  // frame_start restarts the word, so the current bit (if any) becomes bit 0.
  always_comb begin
    cnt_eff   = frame_start ? '0 : cnt_q;
    dir_eff   = (cnt_eff == '0) ? shift_dir : dir_q;
    sreg_base = (cnt_eff == '0) ? '0 : sreg_q;
    dir_d     = dir_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_eff;
    word_done = 1'b0;
    if (shift_en) begin
      dir_d = dir_eff;
      if (cnt_eff < WidthV) begin
        if (dir_eff == DIR_LSB_FIRST) begin
          sreg_d = {serial_in, sreg_base[WIDTH-1:1]};
        end else begin
          sreg_d = {sreg_base[WIDTH-2:0], serial_in};
        end
      end
      if (cnt_eff == LastCntV) begin
        word_done = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_eff + 1'b1;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  // Data is already complete in sreg_q when the parity bit arrives.
  assign word_data = sreg_q;
  assign word_perr = (^sreg_q) ^ serial_in;
`else
  assign word_data = sreg_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      sreg_q <= '0;
      dir_q  <= DIR_MSB_FIRST;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sreg_q <= sreg_d;
      dir_q  <= dir_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign busy = busy_q;

  sipo_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk_i        (clk),
    .rst_ni       (reset),
    .wr_valid_i   (word_done),
    .wr_data_i    (word_data),
`ifdef SIPO_PARITY_EN
    .wr_perr_i    (word_perr),
    .parity_err_o (parity_err),
`endif
    .out_ready_i  (out_ready),
    .data_o       (parallel_out),
    .valid_o      (out_valid),
    .overrun_o    (overrun)
  );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: a cycle model of the holding slot predicts every output.
module tb_sipo_deserializer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset, serial_in, shift_en, shift_dir, frame_start, out_ready;
  logic [W-1:0] parallel_out;
  logic         out_valid, overrun, busy;
`ifdef SIPO_PARITY_EN
  logic         parity_err;
  bit           par_flip = 1'b0;
`endif

  int unsigned  n_chk = 0;
  int unsigned  n_err = 0;
  logic [W:0]   sb_q[$];
  logic         m_valid = 1'b0;
  logic         m_ovr   = 1'b0;
  logic         m_busy  = 1'b0;

  always #5 clk = ~clk;

  sipo_deserializer #(
    .WIDTH (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .shift_en     (shift_en),
    .shift_dir    (shift_dir),
    .frame_start  (frame_start),
    .out_ready    (out_ready),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .overrun      (overrun),
`ifdef SIPO_PARITY_EN
    .parity_err   (parity_err),
`endif
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Check outputs against the model, then advance model and DUT across one clock edge.
  task automatic step(input bit done, input logic [W-1:0] word, input bit perr);
    logic [W:0] head;
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("overrun", 32'(overrun), 32'(m_ovr));
    check_eq("busy", 32'(busy), 32'(m_busy));
    if (m_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
      end else begin
        head = sb_q[0];
        check_eq("data", 32'(parallel_out), 32'(head[W-1:0]));
`ifdef SIPO_PARITY_EN
        check_eq("parity_err", 32'(parity_err), 32'(head[W]));
`endif
        if (out_ready) void'(sb_q.pop_front());
      end
    end
    if (done) begin
      if (!m_valid || out_ready) begin
        sb_q.push_back({perr, word});
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (shift_en || frame_start) m_busy = shift_en && !done;
    if (!reset) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_busy  = 1'b0;
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    shift_en    = 1'b0;
    frame_start = 1'b0;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] word, input bit dir, input bit toggle,
                           input bit fs_first, input bit rdy_last);
    bit last;
`ifdef SIPO_PARITY_EN
    logic par;
`endif
    for (int i = 0; i < W; i++) begin
      shift_en    = 1'b1;
      serial_in   = dir ? word[i] : word[W-1-i];
      shift_dir   = (toggle && (i % 2 == 1)) ? ~dir : dir;
      frame_start = fs_first && (i == 0);
`ifdef SIPO_PARITY_EN
      last = 1'b0;
`else
      last = (i == W - 1);
`endif
      if (rdy_last) out_ready = last;
      step(last, word, 1'b0);
    end
`ifdef SIPO_PARITY_EN
    par         = (^word) ^ par_flip;
    serial_in   = par;
    frame_start = 1'b0;
    shift_dir   = ~dir;
    if (rdy_last) out_ready = 1'b1;
    step(1'b1, word, (^word) ^ par);
`endif
    shift_en    = 1'b0;
    frame_start = 1'b0;
    serial_in   = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    serial_in   = 1'b0;
    shift_en    = 1'b0;
    shift_dir   = 1'b0;
    frame_start = 1'b0;
    out_ready   = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, '0, 1'b0);
    check_eq("rst_data", 32'(parallel_out), 32'd0);
    reset = 1'b1;

    // MSB-first, consumer always ready
    out_ready = 1'b1;
    send_word(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // LSB-first; second word toggles shift_dir mid-word
    send_word(4'b1101, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    send_word(4'b1101, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Overrun: second word dropped while the first is unconsumed
    out_ready = 1'b0;
    send_word(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check_eq("ovr_hold_data", 32'(parallel_out), 32'hb);
    out_ready = 1'b1;
    idle(2);
    check_eq("ovr_sticky", 32'(overrun), 32'd1);

    // Completion coincides with a draining handshake: word replaced, no overrun
    reset = 1'b0;
    step(1'b0, '0, 1'b0);
    reset     = 1'b1;
    out_ready = 1'b0;
    send_word(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    send_word(4'b0101, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    check_eq("replace_no_ovr", 32'(overrun), 32'd0);

    // frame_start discards two stray bits and restarts with the current bit
    out_ready = 1'b1;
    shift_en  = 1'b1;
    shift_dir = 1'b0;
    serial_in = 1'b1;
    step(1'b0, '0, 1'b0);
    serial_in = 1'b1;
    step(1'b0, '0, 1'b0);
    send_word(4'b1011, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Reset mid-word, then a clean word
    shift_en  = 1'b1;
    serial_in = 1'b0;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    shift_en = 1'b0;
    reset    = 1'b0;
    step(1'b0, '0, 1'b0);
    check_eq("midrst_data", 32'(parallel_out), 32'd0);
    reset = 1'b1;
    send_word(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

`ifdef SIPO_PARITY_EN
    par_flip = 1'b0;
    send_word(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    par_flip = 1'b1;
    send_word(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
